// File: rtl/count_sweep_ctrl_if.sv
// Request/status bundle for the up/down sweep sequencer.
// master drives the request side; slave is the sequencer.
interface count_sweep_ctrl_if #(
  parameter int WIDTH  = 4,
  parameter int PASS_W = 3
);
  // start is a level sampled only while the sequencer is idle; there is no ready:
  // an accepted request shows as busy (or done/err) one edge later, others are dropped.
  logic              start;
  logic [WIDTH-1:0]  lo;
  logic [WIDTH-1:0]  hi;
  logic [PASS_W-1:0] passes;
  logic              hold;
  logic              busy;
  logic              done;
  logic              err;
  logic              dir;
  logic              load;
  logic [WIDTH-1:0]  out;
  logic [PASS_W-1:0] pass_cnt;
  logic [2:0]        dbg_state;

  modport master (
    output start, lo, hi, passes, hold,
    input  busy, done, err, dir, load, out, pass_cnt, dbg_state
  );

  modport slave (
    input  start, lo, hi, passes, hold,
    output busy, done, err, dir, load, out, pass_cnt, dbg_state
  );
endinterface

// File: rtl/count_sweep_ctrl.sv
// Sweeps an owned up/down counter lo->hi->lo for a programmed number of passes,
// presenting the plain counter view (dir/load/out) to downstream logic.
module count_sweep_ctrl #(
  parameter int WIDTH  = 4,
  parameter int PASS_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  count_sweep_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_UP   = 3'd2,
    S_DOWN = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_out;
  logic              r_dir;
  logic [PASS_W-1:0] r_pass_cnt;
  logic              r_err;
  logic [WIDTH-1:0]  r_lo;
  logic [WIDTH-1:0]  r_hi;

  state_t            w_state_nxt;
  logic [WIDTH-1:0]  w_out_nxt;
  logic              w_dir_nxt;
  logic [PASS_W-1:0] w_pass_nxt;
  logic              w_err_nxt;
  logic [WIDTH-1:0]  w_lo_nxt;
  logic [WIDTH-1:0]  w_hi_nxt;
  logic [WIDTH-1:0]  w_out_inc;
  logic [WIDTH-1:0]  w_out_dec;

  // out stays within [lo,hi], so these never wrap where they are used.
  assign w_out_inc = r_out + 1'b1;
  assign w_out_dec = r_out - 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_out      <= '0;
      r_dir      <= 1'b0;
      r_pass_cnt <= '0;
      r_err      <= 1'b0;
      r_lo       <= '0;
      r_hi       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_out      <= w_out_nxt;
      r_dir      <= w_dir_nxt;
      r_pass_cnt <= w_pass_nxt;
      r_err      <= w_err_nxt;
      r_lo       <= w_lo_nxt;
      r_hi       <= w_hi_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_dir_nxt   = r_dir;
    w_pass_nxt  = r_pass_cnt;
    w_err_nxt   = r_err;
    w_lo_nxt    = r_lo;
    w_hi_nxt    = r_hi;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if ((bus.passes == '0) || (bus.lo > bus.hi)) begin
            w_state_nxt = S_DONE;
            w_err_nxt   = 1'b1;
          end else begin
            w_lo_nxt    = bus.lo;
            w_hi_nxt    = bus.hi;
            w_pass_nxt  = bus.passes;
            w_state_nxt = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        w_out_nxt = r_lo;
        w_dir_nxt = 1'b1;
        if (r_lo < r_hi) begin
          w_state_nxt = S_UP;
        end else begin
          // Degenerate lo==hi sweep completes without counting any pass.
          w_pass_nxt  = '0;
          w_state_nxt = S_DONE;
        end
      end

      S_UP: begin
        if (!bus.hold) begin
          w_out_nxt = w_out_inc;
          if (w_out_inc == r_hi) begin
            w_dir_nxt   = 1'b0;
            w_state_nxt = S_DOWN;
          end
        end
      end

      S_DOWN: begin
        if (!bus.hold) begin
          w_out_nxt = w_out_dec;
          if (w_out_dec == r_lo) begin
            w_pass_nxt = r_pass_cnt - 1'b1;
            if (r_pass_cnt == PASS_W'(1)) begin
              w_state_nxt = S_DONE;
            end else begin
              w_dir_nxt   = 1'b1;
              w_state_nxt = S_UP;
            end
          end
        end
      end

      S_DONE: begin
        w_err_nxt   = 1'b0;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.busy      = (r_state == S_LOAD) || (r_state == S_UP) || (r_state == S_DOWN);
  assign bus.load      = (r_state == S_LOAD);
  assign bus.done      = (r_state == S_DONE);
  assign bus.err       = r_err;
  assign bus.dir       = r_dir;
  assign bus.out       = r_out;
  assign bus.pass_cnt  = r_pass_cnt;
  assign bus.dbg_state = r_state;

endmodule
